accel_result_reader: RTL

ACCEL_RESULT_READER -- requirements
Module: accel_result_reader

---
 rtl/accel_result_reader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/accel_result_reader.sv
// Streams an accelerator's result buffer out of a synchronous-read memory, one
// word per request/capture/hold cycle, with byte-accurate keep on the final word.
module accel_result_reader #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 16,
    parameter int OUT_BASE_ADDR  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        done,
    input  logic [5:0]                  output_length_byte,
    output logic                        mem_en,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic                        mem_we,
    output logic [MEM_DATA_WIDTH/8-1:0] mem_be,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MEM_DATA_WIDTH-1:0]   out_data,
    output logic [MEM_DATA_WIDTH/8-1:0] out_keep,
    output logic                        out_last,
    output logic                        busy,
    output logic                        rd_done,
    output logic                        overrun
);

    localparam int KW       = MEM_DATA_WIDTH / 8;
    localparam int LAST_MAX = (MEM_DEPTH > 16) ? 15 : ((MEM_DEPTH < 1) ? 0 : MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_HOLD
    } state_e;

    state_e                    state_q, state_d;
    logic [5:0]                len_q, len_d;
    logic [3:0]                wcnt_q, wcnt_d;
    logic [MEM_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KW-1:0]             out_keep_q, out_keep_d;
    logic                      out_last_q, out_last_d;
    logic                      out_valid_q, out_valid_d;
    logic                      rd_done_q, rd_done_d;
    logic                      overrun_q, overrun_d;

    logic                      len_clamped;
    logic [3:0]                last_idx;
    logic                      is_last;
    logic [KW-1:0]             last_keep;

    // A length that would run past the end of the memory is cut at its last word.
    always_comb begin
        len_clamped = (len_q[5:2] > 4'(LAST_MAX));
        last_idx    = len_clamped ? 4'(LAST_MAX) : len_q[5:2];
        is_last     = (wcnt_q == last_idx);
        case (len_q[1:0])
            2'd0:    last_keep = KW'(4'h1);
            2'd1:    last_keep = KW'(4'h3);
            2'd2:    last_keep = KW'(4'h7);
            default: last_keep = KW'(4'hF);
        endcase
        if (len_clamped) begin
            last_keep = '1;
        end
    end

    // NOTE: every signal gets its default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        rd_done_d   = 1'b0;
        overrun_d   = overrun_q | (done && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (done) begin
                    len_d   = output_length_byte;
                    wcnt_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                out_data_d  = mem_rdata;
                out_keep_d  = is_last ? last_keep : '1;
                out_last_d  = is_last;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        rd_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        wcnt_d  = wcnt_q + 4'd1;
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            wcnt_q      <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rd_done_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            rd_done_q   <= rd_done_d;
            overrun_q   <= overrun_d;
        end
    end

    // Memory strobes decode straight from the state, so reset silences them at once.
    assign mem_en    = (state_q == S_REQ);
    assign mem_addr  = mem_en ? (MEM_ADDR_WIDTH'(OUT_BASE_ADDR) + MEM_ADDR_WIDTH'(wcnt_q)) : '0;
    assign mem_we    = 1'b0;
    assign mem_be    = '1;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign rd_done   = rd_done_q;
    assign overrun   = overrun_q;

endmodule
